// File: rtl/stepper_phase_sequencer.sv
// Turns a step-period word and move commands into unipolar stepper coil phases.
// Supports half-step and two-phase full-step modes, bounded moves and a position count.
module stepper_phase_sequencer #(
    parameter int DIV_WIDTH = 16,
    parameter int POS_WIDTH = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] division,
    input  logic                 enable,
    input  logic                 dir,
    input  logic                 half_step,
    input  logic [CNT_WIDTH-1:0] move_steps,
    input  logic                 move_start,
    input  logic                 move_abort,
    output logic [3:0]           phase_out,
    output logic                 step_tick,
    output logic                 busy,
    output logic                 done,
    output logic [POS_WIDTH-1:0] position
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state;
    logic [2:0]           index;
    logic [DIV_WIDTH-1:0] prescaler;
    logic [CNT_WIDTH-1:0] remaining;
    logic [2:0]           step_size;
    logic [2:0]           index_next;
    logic [POS_WIDTH-1:0] position_next;

    function automatic logic [3:0] phase_of(input logic [2:0] i);
        logic [3:0] p;
        p = 4'b0001;
        unique case (i)
            3'd0: p = 4'b0001;
            3'd1: p = 4'b0011;
            3'd2: p = 4'b0010;
            3'd3: p = 4'b0110;
            3'd4: p = 4'b0100;
            3'd5: p = 4'b1100;
            3'd6: p = 4'b1000;
            3'd7: p = 4'b1001;
        endcase
        return p;
    endfunction

    // Full step from an even (single-coil) index moves one entry to land on a two-coil entry.
    always_comb begin
        step_size = 3'd1;
        if (!half_step && index[0])
            step_size = 3'd2;
        index_next    = dir ? index + step_size : index - step_size;
        position_next = dir ? position + POS_WIDTH'(1)
                            : position - POS_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            index     <= 3'd0;
            prescaler <= '0;
            remaining <= '0;
            phase_out <= 4'b0000;
            step_tick <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            position  <= '0;
        end else begin
            step_tick <= 1'b0;
            done      <= 1'b0;
            phase_out <= enable ? phase_of(index) : 4'b0000;
            unique case (state)
                IDLE: begin
                    prescaler <= '0;
                    if (move_start) begin
                        if (move_steps != '0) begin
                            state     <= RUN;
                            remaining <= move_steps;
                            busy      <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (move_abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        remaining <= '0;
                        prescaler <= '0;
                    end else if (!enable || division == '0) begin
                        prescaler <= '0;
                    end else if (prescaler >= division) begin
                        prescaler <= '0;
                        step_tick <= 1'b1;
                        remaining <= remaining - CNT_WIDTH'(1);
                        position  <= position_next;
                        index     <= index_next;
                        if (remaining == CNT_WIDTH'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        prescaler <= prescaler + DIV_WIDTH'(1);
                    end
                end
            endcase
        end
    end

endmodule
